tp_hiscore_seq: RTL
===================

# tp_hiscore_seq

High-score save/restore sequencer for the Time Pilot core, sitting directly upstream of the core's `hs_address`/`hs_data_in`/`hs_write` port and consuming its `hs_data_out`. It holds an internal byte buffer that the MiSTer hiscore loader fills or reads. After power-up it waits for the game's RAM to reach a known signature before writing the saved table into work RAM. On request, it copies the live table back into the buffer so the loader can save it. The core is paused through `pause_req` during every transfer.

## Interface
- `HS_START`, 16'h0000: core address of the first hiscore byte.
- `HS_LEN`, 64: table length in bytes, 1..256.
- `CHECK_ADDR`, 16'h0000: core address polled to detect that the game has initialised RAM.
- `CHECK_VAL`, 8'h00: value at `CHECK_ADDR` that counts as a match.
- `WAIT_FRAMES`, 8'd4: number of consecutive matching frames required before restore, 1..255.

- `clk_49m` in 1: system clock, 49.152 MHz.
- `reset` in 1: synchronous, active-high.
- `vblank` in 1: core `video_vblank`.
- `hs_address` out 16: address to core.
- `hs_data_in` out 8: write data to core.
- `hs_write` out 1: one-cycle write strobe to core.
- `hs_data_out` in 8: read data from core. Valid 2 cycles after `hs_address` is presented.
- `pause_req` out 1: drives the core `pause` input.
- `buf_wr` in 1: loader byte write.
- `buf_addr` in 8: loader address for both read and write.
- `buf_din` in 8: loader write data.
- `buf_dout` out 8: loader read data, 1-cycle latency.
- `save_req` in 1: pulse requesting a dump.
- `save_done` out 1: one-cycle pulse when a dump completes.
- `busy` out 1: high in RESTORE and DUMP.

## Operation
- Buffer: 256x8 single-clock RAM with port A for the loader and port B for the sequencer.
  - Loader writes are ignored while `busy`=1.
  - Any accepted `buf_wr` sets `buf_valid`.
- States: ARMED, PROBE, COMPARE, RESTORE, MONITOR, DUMP.
- ARMED:
  - On a `vblank` rising edge (registered edge detect), go to PROBE.
  - Otherwise, if the frame count has reached `WAIT_FRAMES`, go to RESTORE when `buf_valid`=1, else to MONITOR.
- PROBE: drive `hs_address`=`CHECK_ADDR`, wait 2 cycles, then go to COMPARE.
- COMPARE:
  - If `hs_data_out`==`CHECK_VAL`, increment the 8-bit frame count (saturating); otherwise clear it.
  - Return to ARMED.
- RESTORE, index i from 0 to `HS_LEN`-1, 2 cycles per byte:
  - Cycle 1: present buffer address i.
  - Cycle 2: `hs_address`=`HS_START`+i (16-bit wrap), `hs_data_in`=buf[i], `hs_write`=1.
  - After the last byte, go to MONITOR.
- MONITOR: idle. A pending save starts DUMP.
- DUMP, 3 cycles per byte:
  - Cycle 1: drive `hs_address`=`HS_START`+i.
  - Cycle 2: wait.
  - Cycle 3: write `hs_data_out` into buf[i].
  - After the last byte: pulse `save_done`, go to MONITOR.
- `save_req`:
  - Sets a pending flag in any state.
  - The flag is consumed only on the MONITOR→DUMP transition.
  - A `save_req` arriving during DUMP re-arms the flag, so one further dump follows.
- `pause_req` = (state==RESTORE || state==DUMP). It asserts in the cycle the state is entered.

## Timing
- Reset values:
  - State ARMED; frame count 0; `buf_valid`=0; pending flag 0.
  - `hs_address`=0, `hs_data_in`=0, `hs_write`=0.
  - `pause_req`=0, `save_done`=0, `busy`=0, `buf_dout`=0.
  - Buffer contents are not cleared.
- Reset asserted mid-RESTORE or mid-DUMP aborts the transfer immediately. Outputs return to reset values on the next edge.
- `hs_write` is never high outside RESTORE and is high at most 1 cycle in 2.
- RESTORE lasts 2·`HS_LEN` cycles; DUMP lasts 3·`HS_LEN` cycles. `save_done` is asserted in the cycle after the last capture.
- `vblank` rising edge detection: edge = `vblank` & ~`vblank_q`. An edge that arrives during PROBE or COMPARE is lost; the frame period makes this harmless.
- Simultaneous `buf_wr` and the transition into RESTORE: the write is accepted, because `busy` is still 0 in that cycle.
- Restore happens once per reset. Loading after MONITOR is reached does not trigger another restore.

## Test plan
- `CHECK_VAL`=8'hA5 with RAM model returning A5 from the 1st frame, `WAIT_FRAMES`=4, buffer preloaded 0..63 → exactly 64 `hs_write` pulses starting at the 4th vblank, address `HS_START`+i with data i, `pause_req` high for exactly 128 cycles.
- RAM returns A5, A5, 00, A5×4 → the count clears on 00, and restore starts after the 7th vblank.
- `buf_valid`=0 at signature match → no `hs_write`, `pause_req` stays 0, state reaches MONITOR.
- In MONITOR, RAM holds 8'hFF-i, `save_req` pulse → `save_done` 192 cycles later, loader reads buf[i]=FF-i, and loader writes during DUMP leave the buffer unchanged.
- `save_req` issued during ARMED → dump runs immediately after restore completes.
- Reset at byte 10 of RESTORE → `hs_write`=0 and `pause_req`=0 one cycle later; the sequence restarts from ARMED and requires the full 4-frame match again.

Source files
------------

// File: rtl/tp_hiscore_seq_if.sv
// Core-side hiscore bus between the sequencer (master) and the Time Pilot core (slave).
// The sequencer drives address, write data, write strobe and pause; the core returns read data.
interface tp_hiscore_seq_if;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;
  logic        pause_req;

  modport master (
    output hs_address,
    output hs_data_in,
    output hs_write,
    output pause_req,
    input  hs_data_out
  );

  modport slave (
    input  hs_address,
    input  hs_data_in,
    input  hs_write,
    input  pause_req,
    output hs_data_out
  );
endinterface

// File: rtl/tp_hiscore_seq.sv
// High-score save/restore sequencer: waits for the game's RAM signature, restores the
// buffered table into work RAM once, and dumps the live table back on request.
module tp_hiscore_seq #(
  parameter logic [15:0] HS_START    = 16'h0000,
  parameter int          HS_LEN      = 64,
  parameter logic [15:0] CHECK_ADDR  = 16'h0000,
  parameter logic [7:0]  CHECK_VAL   = 8'h00,
  parameter logic [7:0]  WAIT_FRAMES = 8'd4
) (
  input  logic                    clk_49m,
  input  logic                    reset,
  input  logic                    vblank,
  tp_hiscore_seq_if.master        hs,
  input  logic                    buf_wr,
  input  logic [7:0]              buf_addr,
  input  logic [7:0]              buf_din,
  output logic [7:0]              buf_dout,
  input  logic                    save_req,
  output logic                    save_done,
  output logic                    busy
);

  typedef enum logic [2:0] {ARMED, PROBE, COMPARE, RESTORE, MONITOR, DUMP} state_t;

  localparam logic [7:0] LAST_IDX = 8'(HS_LEN - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_phase;
  logic [7:0] r_idx;
  logic [7:0] r_frames;
  logic       r_buf_valid;
  logic       r_pend;
  logic       r_vblank_q;
  logic       r_save_done;
  logic [7:0] r_buf_dout;
  logic [7:0] r_rd_b;
  logic [7:0] r_mem [0:255];

  logic       w_vb_edge;
  logic       w_last;
  logic       w_capture;
  logic       w_load_ok;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [7:0] w_wdata;

  assign w_vb_edge = vblank & ~r_vblank_q;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_capture = (r_state == DUMP) && (r_phase == 2'd2);
  assign w_load_ok = buf_wr && !busy;

  // Loader and dump writes never coincide (dump implies busy), so one write port serves both.
  assign w_we    = w_load_ok || w_capture;
  assign w_waddr = w_capture ? r_idx : buf_addr;
  assign w_wdata = w_capture ? hs.hs_data_out : buf_din;

  assign buf_dout  = r_buf_dout;
  assign save_done = r_save_done;

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      r_state <= ARMED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARMED: begin
        if (w_vb_edge) begin
          w_state_next = PROBE;
        end else if (r_frames >= WAIT_FRAMES) begin
          w_state_next = r_buf_valid ? RESTORE : MONITOR;
        end
      end
      PROBE: begin
        if (r_phase == 2'd1) begin
          w_state_next = COMPARE;
        end
      end
      COMPARE: begin
        w_state_next = ARMED;
      end
      RESTORE: begin
        if (r_phase[0] && w_last) begin
          w_state_next = MONITOR;
        end
      end
      MONITOR: begin
        if (r_pend) begin
          w_state_next = DUMP;
        end
      end
      DUMP: begin
        if (w_capture && w_last) begin
          w_state_next = MONITOR;
        end
      end
      default: w_state_next = ARMED;
    endcase
  end

  always_comb begin
    hs.hs_address = 16'h0000;
    hs.hs_data_in = 8'h00;
    hs.hs_write   = 1'b0;
    hs.pause_req  = 1'b0;
    busy          = 1'b0;
    case (r_state)
      PROBE, COMPARE: begin
        hs.hs_address = CHECK_ADDR;
      end
      RESTORE: begin
        hs.hs_address = HS_START + {8'h00, r_idx};
        hs.pause_req  = 1'b1;
        busy          = 1'b1;
        if (r_phase[0]) begin
          hs.hs_data_in = r_rd_b;
          hs.hs_write   = 1'b1;
        end
      end
      DUMP: begin
        hs.hs_address = HS_START + {8'h00, r_idx};
        hs.pause_req  = 1'b1;
        busy          = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      r_vblank_q  <= 1'b0;
      r_frames    <= 8'h00;
      r_buf_valid <= 1'b0;
      r_pend      <= 1'b0;
      r_phase     <= 2'd0;
      r_idx       <= 8'h00;
      r_save_done <= 1'b0;
      r_buf_dout  <= 8'h00;
    end else begin
      r_vblank_q  <= vblank;
      r_buf_dout  <= r_mem[buf_addr];
      r_save_done <= w_capture && w_last;
      if (w_load_ok) begin
        r_buf_valid <= 1'b1;
      end
      // A new request always wins, so a request landing during DUMP queues one more dump.
      r_pend <= save_req || (r_pend && (r_state != MONITOR));
      if (r_state == COMPARE) begin
        if (hs.hs_data_out == CHECK_VAL) begin
          r_frames <= (r_frames == 8'hFF) ? r_frames : r_frames + 8'd1;
        end else begin
          r_frames <= 8'h00;
        end
      end
      if (w_state_next != r_state) begin
        r_phase <= 2'd0;
        r_idx   <= 8'h00;
      end else begin
        case (r_state)
          PROBE: begin
            r_phase <= r_phase + 2'd1;
          end
          RESTORE: begin
            if (r_phase[0]) begin
              r_phase <= 2'd0;
              r_idx   <= r_idx + 8'd1;
            end else begin
              r_phase <= 2'd1;
            end
          end
          DUMP: begin
            if (r_phase == 2'd2) begin
              r_phase <= 2'd0;
              r_idx   <= r_idx + 8'd1;
            end else begin
              r_phase <= r_phase + 2'd1;
            end
          end
          default: begin
            r_phase <= 2'd0;
          end
        endcase
      end
    end
  end

  // Buffer contents survive reset; port B read data is ready one cycle after r_idx is presented.
  always_ff @(posedge clk_49m) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_rd_b <= r_mem[r_idx];
  end

endmodule
